// File: rtl/i2c_cfg_sequencer_pkg.sv
// i2c_cfg_pkg: shared state encoding and derived constants for the I2C config sequencer.
package i2c_cfg_pkg;
    typedef enum logic [3:0] {
        PWRUP, IDLE, FETCH, ISSUE, WAIT, DELAY, GAP, NEXT, DONE, ERROR, RD_ISSUE, RD_WAIT
    } state_t;

    function automatic logic [63:0] delay_mark(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Clocks per millisecond; never below one so slow test clocks still tick.
    function automatic int unsigned ms_div(input int unsigned f);
        return (f >= 2000) ? f / 1000 : 1;
    endfunction
endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// i2c_cfg_if: write/readback handshake between the sequencer and the I2C master.
// CFG_READBACK_EN adds the rd qualifier for readback transactions.
interface i2c_cfg_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              nack;
`ifdef CFG_READBACK_EN
    logic              rd;
`endif
    modport master (
        output req, addr, wdata,
`ifdef CFG_READBACK_EN
        output rd,
`endif
        input  ack, nack, rdata
    );
    modport slave (
        input  req, addr, wdata,
`ifdef CFG_READBACK_EN
        input  rd,
`endif
        output ack, nack, rdata
    );
endinterface

// File: rtl/i2c_cfg_sequencer_delay_timer.sv
// i2c_cfg_delay_timer: down-counter in ms or cycle units; comes out of reset loaded with the power-up wait.
module i2c_cfg_delay_timer #(
    parameter int unsigned DIV     = 1,
    parameter int unsigned RST_CNT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        ms_i,
    input  logic [31:0] cnt_i,
    output logic        done_o
);
    logic [31:0] rem_q, pre_q;
    logic        ms_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= RST_CNT;
            pre_q <= DIV - 1;
            ms_q  <= 1'b1;
        end else if (load_i) begin
            rem_q <= cnt_i;
            pre_q <= DIV - 1;
            ms_q  <= ms_i;
        end else if (rem_q != 32'd0) begin
            if (!ms_q || pre_q == 32'd0) begin
                rem_q <= rem_q - 32'd1;
                pre_q <= DIV - 1;
            end else begin
                pre_q <= pre_q - 32'd1;
            end
        end
    end

    assign done_o = rem_q == 32'd0;
endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a combinational {addr,data} LUT and issues each entry as an I2C write.
// CFG_READBACK_EN: verify every write with a readback of the same address.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 8,
    parameter int          IDX_W      = 8,
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned POWERUP_MS = 20,
    parameter int unsigned GAP_CYC    = 1000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    output logic [IDX_W-1:0]         lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    input  logic [IDX_W-1:0]         lut_size,
    i2c_cfg_if.master                bus,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_error,
    output logic [IDX_W-1:0]         err_index
);
    localparam logic [ADDR_W-1:0] MARK   = ADDR_W'(delay_mark(ADDR_W));
    localparam logic [31:0]       GAP_LD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, size_q, size_d, err_idx_q, err_idx_d, cur_size;
    logic [7:0]        retry_q, retry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_q, req_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              rd_q, rd_d, rb_fail, t_load, t_ms, t_done;
    logic [31:0]       t_cnt;

    i2c_cfg_delay_timer #(.DIV(ms_div(CLK_FREQ)), .RST_CNT(POWERUP_MS)) u_timer (
        .clk(clk), .rst(rst), .load_i(t_load), .ms_i(t_ms), .cnt_i(t_cnt), .done_o(t_done)
    );

`ifdef CFG_READBACK_EN
    assign rb_fail = state_q == RD_WAIT && (bus.nack || (bus.ack && bus.rdata != wdata_q));
    assign bus.rd  = rd_q;
`else
    assign rb_fail = 1'b0;
`endif

    // The first fetch sees the live size; later fetches use the latched copy.
    assign cur_size = (idx_q == '0) ? lut_size : size_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        size_d    = size_q;
        retry_d   = retry_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_d     = 1'b0;
        rd_d      = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        t_load    = 1'b0;
        t_ms      = 1'b0;
        t_cnt     = '0;
        case (state_q)
            PWRUP: state_d = t_done ? FETCH : PWRUP;
            IDLE, DONE, ERROR: if (cfg_start) begin
                state_d = FETCH;
                idx_d   = '0;
                retry_d = '0;
                done_d  = 1'b0;
                error_d = 1'b0;
            end
            FETCH: begin
                addr_d  = lut_data[ADDR_W+DATA_W-1:DATA_W];
                wdata_d = lut_data[DATA_W-1:0];
                size_d  = cur_size;
                if (idx_q == cur_size) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (lut_data[ADDR_W+DATA_W-1:DATA_W] == MARK) begin
                    state_d = DELAY;
                    t_load  = 1'b1;
                    t_ms    = 1'b1;
                    t_cnt   = 32'(lut_data[DATA_W-1:0]);
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_d   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                req_d = !(bus.ack || bus.nack);
                if (bus.ack && !bus.nack) begin
`ifdef CFG_READBACK_EN
                    state_d = RD_ISSUE;
`else
                    state_d = GAP;
                    t_load  = 1'b1;
                    t_cnt   = GAP_LD;
`endif
                end
            end
`ifdef CFG_READBACK_EN
            RD_ISSUE: begin
                req_d   = 1'b1;
                rd_d    = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                req_d = !(bus.ack || bus.nack);
                rd_d  = req_d;
                if (bus.ack && !rb_fail) begin
                    state_d = GAP;
                    t_load  = 1'b1;
                    t_cnt   = GAP_LD;
                end
            end
`endif
            DELAY, GAP: state_d = t_done ? NEXT : state_q;
            NEXT: begin
                idx_d   = idx_q + 1'b1;
                retry_d = '0;
                state_d = FETCH;
            end
            default: state_d = PWRUP;
        endcase
        if ((state_q == WAIT && bus.nack) || rb_fail) begin
            if (retry_q < 8'(MAX_RETRY)) begin
                retry_d = retry_q + 8'd1;
                state_d = ISSUE;
            end else begin
                state_d   = ERROR;
                error_d   = 1'b1;
                err_idx_d = idx_q;
            end
        end
        busy_d = !(state_d inside {IDLE, DONE, ERROR});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PWRUP;
            idx_q     <= '0;
            size_q    <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            size_q    <= size_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign lut_index = idx_q;
    assign bus.req   = req_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;
    assign err_index = err_idx_q;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: directed bench with an I2C master model that acks after a fixed latency.
module tb_i2c_cfg_sequencer;
    localparam int AW = 16, DW = 8, IW = 8, LAT = 10;

    logic clk = 1'b0, rst = 1'b1, cfg_start = 1'b0;
    logic [IW-1:0] lut_index, err_index;
    logic [IW-1:0] lut_size = '0;
    logic [AW+DW-1:0] lut_mem [0:15];
    logic [AW+DW-1:0] lut_data;
    logic cfg_busy, cfg_done, cfg_error, is_rd, rd_bad = 1'b0;
    logic [AW-1:0] nack_addr = '0;
    int passed = 0, fails = 0, checks = 0, cyc = 0, nack_left = 0, t0 = 0;
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    int log_cyc [$];

    i2c_cfg_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    i2c_cfg_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .CLK_FREQ(100000),
        .POWERUP_MS(2), .GAP_CYC(20), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .lut_index(lut_index),
        .lut_data(lut_data), .lut_size(lut_size), .bus(bus), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index)
    );

`ifdef CFG_READBACK_EN
    assign is_rd = bus.rd;
`else
    assign is_rd = 1'b0;
`endif
    assign lut_data = lut_mem[lut_index[3:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: logs writes, answers each request LAT cycles after it is seen.
    initial begin
        bus.ack = 1'b0; bus.nack = 1'b0; bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1) begin
                if (!is_rd) begin
                    log_addr.push_back(bus.addr);
                    log_data.push_back(bus.wdata);
                    log_cyc.push_back(cyc);
                end
                repeat (LAT - 1) @(negedge clk);
                bus.rdata = rd_bad ? ~bus.wdata : bus.wdata;
                if (nack_left > 0 && bus.addr == nack_addr) begin
                    bus.nack = 1'b1;
                    nack_left--;
                end else begin
                    bus.ack = 1'b1;
                end
                @(negedge clk);
                bus.ack = 1'b0; bus.nack = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic start_pulse();
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!((cfg_done || cfg_error) && !cfg_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (bus.req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        lut_mem[0] = {16'h1234, 8'hAA};
        lut_mem[1] = {16'h0056, 8'hBB};
        lut_mem[2] = {16'h789A, 8'hCC};
        lut_size = 8'd3;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_error", 32'(cfg_error), 32'd0);
        chk("rst_index", 32'(lut_index), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        rst = 1'b0;
        t0 = cyc;

        wait_end("seq3_timeout", 2000);
        chk("seq3_nreq", 32'(log_addr.size()), 32'd3);
        chk("seq3_addr0", 32'(log_addr[0]), 32'h1234);
        chk("seq3_data0", 32'(log_data[0]), 32'hAA);
        chk("seq3_addr1", 32'(log_addr[1]), 32'h0056);
        chk("seq3_data1", 32'(log_data[1]), 32'hBB);
        chk("seq3_addr2", 32'(log_addr[2]), 32'h789A);
        chk("seq3_data2", 32'(log_data[2]), 32'hCC);
        chk("seq3_done", 32'(cfg_done), 32'd1);
        chk("seq3_error", 32'(cfg_error), 32'd0);
        chk("pwrup_wait", 32'((log_cyc[0] - t0) >= 200), 32'd1);

        lut_mem[0] = {16'h1111, 8'h01};
        lut_mem[1] = {16'hFFFF, 8'h05};
        lut_mem[2] = {16'h2222, 8'h02};
        clear_log();
        start_pulse();
        wait_end("delay_timeout", 3000);
        chk("delay_nreq", 32'(log_addr.size()), 32'd2);
        chk("delay_addr0", 32'(log_addr[0]), 32'h1111);
        chk("delay_addr1", 32'(log_addr[1]), 32'h2222);
        chk("delay_span", 32'((log_cyc[1] - log_cyc[0]) >= 500), 32'd1);
        chk("delay_done", 32'(cfg_done), 32'd1);

        lut_mem[0] = {16'h0101, 8'h10};
        lut_mem[1] = {16'h0202, 8'h20};
        lut_mem[2] = {16'h3333, 8'h30};
        nack_addr = 16'h3333;
        nack_left = 2;
        clear_log();
        start_pulse();
        wait_end("retry_timeout", 3000);
        chk("retry_nreq", 32'(log_addr.size()), 32'd5);
        chk("retry_addr2", 32'(log_addr[2]), 32'h3333);
        chk("retry_addr3", 32'(log_addr[3]), 32'h3333);
        chk("retry_addr4", 32'(log_addr[4]), 32'h3333);
        chk("retry_done", 32'(cfg_done), 32'd1);
        chk("retry_error", 32'(cfg_error), 32'd0);

        lut_mem[3] = {16'h0404, 8'h40};
        lut_mem[4] = {16'h5555, 8'h55};
        lut_size = 8'd5;
        nack_addr = 16'h5555;
        nack_left = 4;
        clear_log();
        start_pulse();
        wait_end("err_timeout", 5000);
        chk("err_flag", 32'(cfg_error), 32'd1);
        chk("err_done", 32'(cfg_done), 32'd0);
        chk("err_index", 32'(err_index), 32'd4);
        chk("err_nreq", 32'(log_addr.size()), 32'd8);
        repeat (50) @(negedge clk);
        chk("err_quiet", 32'(log_addr.size()), 32'd8);
        chk("err_busy", 32'(cfg_busy), 32'd0);
        clear_log();
        start_pulse();
        chk("restart_index", 32'(lut_index), 32'd0);
        chk("restart_error", 32'(cfg_error), 32'd0);
        chk("restart_busy", 32'(cfg_busy), 32'd1);
        wait_end("restart_timeout", 3000);
        chk("restart_done", 32'(cfg_done), 32'd1);
        chk("restart_nreq", 32'(log_addr.size()), 32'd5);

        lut_size = 8'd0;
        clear_log();
        start_pulse();
        wait_end("empty_timeout", 500);
        chk("empty_done", 32'(cfg_done), 32'd1);
        chk("empty_nreq", 32'(log_addr.size()), 32'd0);

        lut_size = 8'd3;
        start_pulse();
        wait_req("abort_wait", 500);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("abort_req", 32'(bus.req), 32'd0);
        chk("abort_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        t0 = cyc;
        repeat (2) @(negedge clk);
        clear_log();
        wait_end("abort_timeout", 3000);
        chk("abort_pwrup", 32'((log_cyc[0] - t0) >= 200), 32'd1);
        chk("abort_nreq", 32'(log_addr.size()), 32'd3);
        chk("abort_done", 32'(cfg_done), 32'd1);

`ifdef CFG_READBACK_EN
        lut_mem[0] = {16'h4444, 8'h11};
        lut_size = 8'd1;
        rd_bad = 1'b1;
        clear_log();
        start_pulse();
        wait_end("rb_timeout", 3000);
        chk("rb_error", 32'(cfg_error), 32'd1);
        chk("rb_err_index", 32'(err_index), 32'd0);
        chk("rb_nwrites", 32'(log_addr.size()), 32'd4);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
